// File: rtl/compare_pipeline.sv
// Two-stage multi-lane RISC-V branch comparator with valid/ready flow control.
// S1 captures the operands, S2 holds the evaluated lane results and reductions.
module compare_pipeline #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  in_op,
    input  logic [LANES-1:0]            in_mask,
    input  logic [TAG_WIDTH-1:0]        in_tag,
    input  logic [LANES*DATA_WIDTH-1:0] in_v1,
    input  logic [LANES*DATA_WIDTH-1:0] in_v2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES-1:0]            out_result,
    output logic                        out_any,
    output logic                        out_all,
    output logic                        out_illegal,
    output logic [TAG_WIDTH-1:0]        out_tag
);

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b100;
    localparam logic [2:0] OP_GE  = 3'b101;
    localparam logic [2:0] OP_LTU = 3'b110;
    localparam logic [2:0] OP_GEU = 3'b111;

    logic                        s1_valid;
    logic [2:0]                  s1_op;
    logic [LANES-1:0]            s1_mask;
    logic [TAG_WIDTH-1:0]        s1_tag;
    logic [LANES*DATA_WIDTH-1:0] s1_v1;
    logic [LANES*DATA_WIDTH-1:0] s1_v2;

    logic                        s2_adv;
    logic                        s1_adv;

    logic [LANES-1:0]            lane_res;
    logic                        illegal_op;
    logic [DATA_WIDTH-1:0]       lane_a;
    logic [DATA_WIDTH-1:0]       lane_b;
    logic                        lane_hit;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_mask  <= '0;
            s1_tag   <= '0;
            s1_v1    <= '0;
            s1_v2    <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op   <= in_op;
                s1_mask <= in_mask;
                s1_tag  <= in_tag;
                s1_v1   <= in_v1;
                s1_v2   <= in_v2;
            end
        end
    end

    // Illegal funct3 values suppress every lane; masked-off lanes always read 0.
    always_comb begin
        lane_res   = '0;
        lane_a     = '0;
        lane_b     = '0;
        lane_hit   = 1'b0;
        illegal_op = (s1_op == 3'b010) || (s1_op == 3'b011);
        for (int i = 0; i < LANES; i++) begin
            lane_a = s1_v1[i*DATA_WIDTH +: DATA_WIDTH];
            lane_b = s1_v2[i*DATA_WIDTH +: DATA_WIDTH];
            case (s1_op)
                OP_EQ:   lane_hit = (lane_a == lane_b);
                OP_NE:   lane_hit = (lane_a != lane_b);
                OP_LT:   lane_hit = ($signed(lane_a) <  $signed(lane_b));
                OP_GE:   lane_hit = ($signed(lane_a) >= $signed(lane_b));
                OP_LTU:  lane_hit = (lane_a <  lane_b);
                OP_GEU:  lane_hit = (lane_a >= lane_b);
                default: lane_hit = 1'b0;
            endcase
            lane_res[i] = lane_hit && s1_mask[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_any     <= 1'b0;
            out_all     <= 1'b0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result  <= lane_res;
                out_any     <= |lane_res;
                out_all     <= (s1_mask != '0) && (lane_res == s1_mask);
                out_illegal <= illegal_op;
                out_tag     <= s1_tag;
            end
        end
    end

endmodule
